// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//
// Control sequencer for an FIR delay-line / tap-select register bank.
// Each accepted input sample produces one shift-enable pulse to the delay
// line, then the tap select walks taps 0..Num_coef-1.  The MAC strobes and
// the coefficient address trail the tap select by one cycle, because the
// delay line registers the tap select before the tap data appears.
//
// Parameters
//   Num_coef     number of taps (>= 2)
//   SW           tap select / coefficient address width, ceil(log2(Num_coef))
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   sample_valid one-cycle strobe: new sample on the delay-line input
//   ce           shift enable to the delay line
//   sel          tap select to the delay line
//   coef_addr    coefficient ROM address, aligned with the tap data
//   mac_en       MAC accumulate enable
//   mac_first    first product of a sample (MAC loads instead of adding)
//   mac_last     last product of a sample
//   out_valid    one-cycle pulse: accumulator holds the finished output
//   busy         a sample is being processed
//   overrun      one-cycle pulse: a sample_valid was dropped
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
  parameter  int Num_coef = 17,
  localparam int SW       = $clog2(Num_coef)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  output logic          ce,
  output logic [SW-1:0] sel,
  output logic [SW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          mac_last,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  localparam logic [SW-1:0] LAST_TAP = SW'(Num_coef - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [SW-1:0] tap_reg;
  logic [SW-1:0] tap_next;

  logic          ce_next;
  logic [SW-1:0] sel_next;
  logic [SW-1:0] coef_addr_next;
  logic          mac_en_next;
  logic          mac_first_next;
  logic          mac_last_next;
  logic          out_valid_next;
  logic          busy_next;
  logic          overrun_next;

  // -------------------------------------------------------------------------
  // State and tap counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      tap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tap_reg   <= tap_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and next values of the registered outputs.
  //
  // Delay-line side outputs (ce, sel, busy) are registered copies of the
  // *next* state so they line up with the state itself.  MAC side outputs
  // are registered copies of the *current* state, which yields the one-cycle
  // lag matching the delay line's internal sel register.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    tap_next     = tap_reg;
    overrun_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sample_valid) begin
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        // A new sample cannot be taken while the delay line is mid-sequence.
        overrun_next = sample_valid;
        tap_next     = '0;
        state_next   = SCAN;
      end

      SCAN: begin
        overrun_next = sample_valid;
        if (tap_reg == LAST_TAP) begin
          // Counter holds at the last tap; it is reloaded on the next SHIFT.
          state_next = DRAIN;
        end else begin
          tap_next = tap_reg + 1'b1;
        end
      end

      DRAIN: begin
        // Final MAC cycle; accepting here gives back-to-back operation.
        if (sample_valid) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    ce_next        = (state_next == SHIFT);
    sel_next       = (state_next == SCAN) ? tap_next : '0;
    busy_next      = (state_next != IDLE);

    mac_en_next    = (state_reg == SCAN);
    coef_addr_next = (state_reg == SCAN) ? tap_reg : '0;
    mac_first_next = (state_reg == SCAN) && (tap_reg == '0);
    mac_last_next  = (state_reg == SCAN) && (tap_reg == LAST_TAP);

    // Accumulator is complete the cycle after the last product.
    out_valid_next = mac_last;
  end

  // -------------------------------------------------------------------------
  // Output registers.  Reset clears mac_last as well, so an abandoned sample
  // never produces out_valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce        <= 1'b0;
      sel       <= '0;
      coef_addr <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ce        <= ce_next;
      sel       <= sel_next;
      coef_addr <= coef_addr_next;
      mac_en    <= mac_en_next;
      mac_first <= mac_first_next;
      mac_last  <= mac_last_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
      overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
//
// Self-checking bench.  The reference model keeps the list of accepted sample
// cycles and the cycles where a sample was dropped; every output at cycle t is
// derived from the distance between t and those accept cycles.  A second
// instance with Num_coef=2 covers the small-parameter corner.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

  localparam int N   = 17;
  localparam int SW  = $clog2(N);
  localparam int N2  = 2;
  localparam int SW2 = $clog2(N2);

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic          ce;
  logic [SW-1:0] sel;
  logic [SW-1:0] coef_addr;
  logic          mac_en, mac_first, mac_last, out_valid, busy, overrun;

  logic           sv2;
  logic           ce2;
  logic [SW2-1:0] sel2;
  logic [SW2-1:0] coef2;
  logic           mac_en2, first2, last2, ov2, busy2, ovr2;

  always #5 clk = ~clk;

  fir_tap_sequencer #(.Num_coef(N)) u_dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .ce(ce), .sel(sel), .coef_addr(coef_addr),
    .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  fir_tap_sequencer #(.Num_coef(N2)) u_dut2 (
    .clk(clk), .rst(rst), .sample_valid(sv2),
    .ce(ce2), .sel(sel2), .coef_addr(coef2),
    .mac_en(mac_en2), .mac_first(first2), .mac_last(last2),
    .out_valid(ov2), .busy(busy2), .overrun(ovr2)
  );

  typedef struct packed {
    logic          ce;
    logic [SW-1:0] sel;
    logic [SW-1:0] coef;
    logic          mac_en;
    logic          first;
    logic          last;
    logic          ov;
    logic          busy;
    logic          ovr;
  } outs_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int acc_q[$];
  bit drop_at[int];

  int log_ce[int], log_sel[int], log_first[int], log_last[int];
  int log_ov[int], log_busy[int], log_ovr[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected outputs at cycle t from the accept history.
  function automatic outs_t model(input int t);
    outs_t e;
    e = '0;
    foreach (acc_q[i]) begin
      int d;
      d = t - acc_q[i];
      if (d == 1) e.ce = 1'b1;
      if (d >= 2 && d <= N + 1) e.sel = SW'(d - 2);
      if (d >= 3 && d <= N + 2) begin
        e.mac_en = 1'b1;
        e.coef   = SW'(d - 3);
      end
      if (d == 3)                e.first = 1'b1;
      if (d == N + 2)            e.last  = 1'b1;
      if (d == N + 3)            e.ov    = 1'b1;
      if (d >= 1 && d <= N + 2)  e.busy  = 1'b1;
    end
    e.ovr = drop_at.exists(t - 1);
    return e;
  endfunction

  // Compare process: every cycle, mid-cycle.
  always @(negedge clk) begin
    outs_t e;
    if (cyc > 0) begin
      e = rst ? '0 : model(cyc);
      chk("ce",        32'(ce),        32'(e.ce));
      chk("sel",       32'(sel),       32'(e.sel));
      chk("coef_addr", 32'(coef_addr), 32'(e.coef));
      chk("mac_en",    32'(mac_en),    32'(e.mac_en));
      chk("mac_first", 32'(mac_first), 32'(e.first));
      chk("mac_last",  32'(mac_last),  32'(e.last));
      chk("out_valid", 32'(out_valid), 32'(e.ov));
      chk("busy",      32'(busy),      32'(e.busy));
      chk("overrun",   32'(overrun),   32'(e.ovr));
      log_ce[cyc]    = int'(ce);
      log_sel[cyc]   = int'(sel);
      log_first[cyc] = int'(mac_first);
      log_last[cyc]  = int'(mac_last);
      log_ov[cyc]    = int'(out_valid);
      log_busy[cyc]  = int'(busy);
      log_ovr[cyc]   = int'(overrun);
    end
  end

  // Drive sample_valid for the current cycle, update the model, advance.
  task automatic step(input bit sv);
    sample_valid = sv;
    if (sv && !rst) begin
      if (acc_q.size() == 0 || cyc >= acc_q[$] + N + 2) begin
        acc_q.push_back(cyc);
        if (acc_q.size() > 3) void'(acc_q.pop_front());
      end else begin
        drop_at[cyc] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset between clock edges and check outputs clear at once.
  task automatic reset_mid();
    sample_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst ce",        32'(ce),        0);
    chk("rst sel",       32'(sel),       0);
    chk("rst coef_addr", 32'(coef_addr), 0);
    chk("rst mac_en",    32'(mac_en),    0);
    chk("rst busy",      32'(busy),      0);
    chk("rst mac_last",  32'(mac_last),  0);
    acc_q.delete();
    drop_at.delete();
    step(0);
    step(0);
    rst = 1'b0;
  endtask

  int c, r, n;

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sv2          = 1'b0;
    repeat (3) step(0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ce",   32'(ce),   0);
    rst = 1'b0;
    repeat (2) step(0);

    // Single sample
    c = cyc;
    step(1);
    repeat (25) step(0);
    chk("single ce C+1",       log_ce[c + 1],    1);
    chk("single ce C+2",       log_ce[c + 2],    0);
    chk("single sel C+2",      log_sel[c + 2],   0);
    chk("single sel C+18",     log_sel[c + 18],  16);
    chk("single first C+3",    log_first[c + 3], 1);
    chk("single last C+19",    log_last[c + 19], 1);
    chk("single out_valid C+20", log_ov[c + 20], 1);
    chk("single busy C+19",    log_busy[c + 19], 1);
    chk("single busy C+20",    log_busy[c + 20], 0);

    // Back-to-back: second sample in DRAIN
    c = cyc;
    step(1);
    repeat (18) step(0);
    step(1);
    repeat (22) step(0);
    chk("b2b ce C+20",         log_ce[c + 20], 1);
    chk("b2b out_valid C+20",  log_ov[c + 20], 1);
    chk("b2b out_valid C+39",  log_ov[c + 39], 1);
    chk("b2b overrun C+20",    log_ovr[c + 20], 0);

    // Overrun during scan
    c = cyc;
    step(1);
    repeat (4) step(0);
    step(1);
    repeat (20) step(0);
    chk("ovr overrun C+6",     log_ovr[c + 6], 1);
    chk("ovr overrun C+7",     log_ovr[c + 7], 0);
    chk("ovr ce C+6",          log_ce[c + 6],  0);
    chk("ovr out_valid C+20",  log_ov[c + 20], 1);

    // Reset mid-scan, then restart
    c = cyc;
    step(1);
    repeat (7) step(0);
    reset_mid();
    r = cyc;
    step(1);
    repeat (25) step(0);
    n = 0;
    for (int i = c; i < r; i++) n += log_ov[i];
    chk("rst no out_valid",    n, 0);
    chk("rst restart ce R+1",  log_ce[r + 1],  1);
    chk("rst restart sel R+2", log_sel[r + 2], 0);
    chk("rst restart sel R+3", log_sel[r + 3], 1);

    // sample_valid held high for 60 cycles
    c = cyc;
    repeat (60) step(1);
    repeat (25) step(0);
    chk("held ce C+1",  log_ce[c + 1],  1);
    chk("held ce C+20", log_ce[c + 20], 1);
    chk("held ce C+39", log_ce[c + 39], 1);
    chk("held ce C+58", log_ce[c + 58], 1);
    n = 0;
    for (int i = 2; i <= 19; i++) n += log_ovr[c + i];
    chk("held overrun count", n, 18);
    chk("held overrun C+20", log_ovr[c + 20], 0);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) reset_mid();
      step($urandom_range(0, 5) == 0);
    end
    repeat (25) step(0);

    // Num_coef = 2 corner
    sv2 = 1'b1;
    step(0);
    sv2 = 1'b0;
    chk("n2 ce C+1",        32'(ce2),    1);
    step(0);
    chk("n2 sel C+2",       32'(sel2),   0);
    chk("n2 busy C+2",      32'(busy2),  1);
    step(0);
    chk("n2 sel C+3",       32'(sel2),   1);
    chk("n2 first C+3",     32'(first2), 1);
    chk("n2 coef C+3",      32'(coef2),  0);
    step(0);
    chk("n2 last C+4",      32'(last2),  1);
    chk("n2 coef C+4",      32'(coef2),  1);
    chk("n2 sel C+4",       32'(sel2),   0);
    step(0);
    chk("n2 out_valid C+5", 32'(ov2),    1);
    chk("n2 busy C+5",      32'(busy2),  0);
    step(0);
    chk("n2 out_valid C+6", 32'(ov2),    0);
    chk("n2 overrun",       32'(ovr2),   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
